// File: rtl/max_stream_reduce_if.sv
// Stream bundle for max_stream_reduce: operand beats in, one result per frame out.
// out_idx/out_beat exist only when MAX_ARGMAX_EN is defined.
interface max_stream_reduce_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned IW    = ($clog2(N) > 0) ? $clog2(N) : 1
);
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_max;
`ifdef MAX_ARGMAX_EN
    logic [IW-1:0]      out_idx;
    logic [15:0]        out_beat;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_beat
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_beat
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max
    );
`endif
endinterface

// File: rtl/max_stream_reduce.sv
// Pipelined N-channel max reducer with per-frame running-max accumulator.
// Define MAX_ARGMAX_EN to add winning channel index and beat number tracking.
module max_stream_reduce #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N      = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    max_stream_reduce_if.slave bus
);
    localparam int unsigned L  = $clog2(N);
    localparam int unsigned IW = (L > 0) ? L : 1;

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic w_adv;

    // Heap-ordered tree: node i has children 2i, 2i+1; leaves N..2N-1 are in_data.
    logic [WIDTH-1:0] r_node [1:N-1];
    logic [WIDTH-1:0] w_node [1:2*N-1];
    logic [L:1]       r_sv;
    logic [L:1]       r_sl;

    logic             w_bval;
    logic             w_blast;
    logic [WIDTH-1:0] w_bmax;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_acc_max;
    logic [WIDTH-1:0] w_m_max;
    logic             w_ld_out;
    logic             w_ld_acc;
    logic             r_ov;
    logic [WIDTH-1:0] r_omax;

`ifdef MAX_ARGMAX_EN
    logic [IW-1:0] r_nidx [1:N-1];
    logic [IW-1:0] w_nidx [1:2*N-1];
    logic [IW-1:0] r_acc_idx;
    logic [IW-1:0] w_m_idx;
    logic [15:0]   r_acc_beat;
    logic [15:0]   w_m_beat;
    logic [15:0]   r_bcnt;
    logic [15:0]   w_bcnt_nxt;
    logic [IW-1:0] r_oidx;
    logic [15:0]   r_obeat;
`endif

    assign w_adv = !r_ov || bus.out_ready;

    always_comb begin
        for (int i = 1; i < N; i++) begin
            w_node[i] = r_node[i];
        end
        for (int i = 0; i < N; i++) begin
            w_node[N+i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef MAX_ARGMAX_EN
    always_comb begin
        for (int i = 1; i < N; i++) begin
            w_nidx[i] = r_nidx[i];
        end
        for (int i = 0; i < N; i++) begin
            w_nidx[N+i] = IW'(i);
        end
    end
`endif

    // Left child holds the lower channel indices, so it wins ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < N; i++) begin
                r_node[i] <= '0;
`ifdef MAX_ARGMAX_EN
                r_nidx[i] <= '0;
`endif
            end
        end else if (w_adv) begin
            for (int i = 1; i < N; i++) begin
                if (f_gt(w_node[2*i+1], w_node[2*i])) begin
                    r_node[i] <= w_node[2*i+1];
`ifdef MAX_ARGMAX_EN
                    r_nidx[i] <= w_nidx[2*i+1];
`endif
                end else begin
                    r_node[i] <= w_node[2*i];
`ifdef MAX_ARGMAX_EN
                    r_nidx[i] <= w_nidx[2*i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sv <= '0;
            r_sl <= '0;
        end else if (w_adv) begin
            r_sv[1] <= bus.in_valid;
            r_sl[1] <= bus.in_last;
            for (int s = 2; s <= L; s++) begin
                r_sv[s] <= r_sv[s-1];
                r_sl[s] <= r_sl[s-1];
            end
        end
    end

    assign w_bval  = r_sv[L];
    assign w_blast = r_sl[L];
    assign w_bmax  = w_node[1];

    always_comb begin
        w_state_nxt = r_state;
        w_ld_out    = 1'b0;
        w_ld_acc    = 1'b0;
        w_m_max     = w_bmax;
`ifdef MAX_ARGMAX_EN
        w_m_idx     = w_nidx[1];
        w_m_beat    = '0;
        w_bcnt_nxt  = r_bcnt;
`endif
        // Earlier beat keeps the accumulator on ties.
        if (r_state == StAcc) begin
            if (f_gt(w_bmax, r_acc_max)) begin
`ifdef MAX_ARGMAX_EN
                w_m_beat = r_bcnt;
`endif
            end else begin
                w_m_max  = r_acc_max;
`ifdef MAX_ARGMAX_EN
                w_m_idx  = r_acc_idx;
                w_m_beat = r_acc_beat;
`endif
            end
        end
        if (w_adv && w_bval) begin
            if (w_blast) begin
                w_state_nxt = StIdle;
                w_ld_out    = 1'b1;
`ifdef MAX_ARGMAX_EN
                w_bcnt_nxt  = '0;
`endif
            end else begin
                w_state_nxt = StAcc;
                w_ld_acc    = 1'b1;
`ifdef MAX_ARGMAX_EN
                w_bcnt_nxt  = (r_bcnt == 16'hFFFF) ? r_bcnt : r_bcnt + 16'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_acc_max  <= '0;
            r_ov       <= 1'b0;
            r_omax     <= '0;
`ifdef MAX_ARGMAX_EN
            r_acc_idx  <= '0;
            r_acc_beat <= '0;
            r_bcnt     <= '0;
            r_oidx     <= '0;
            r_obeat    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef MAX_ARGMAX_EN
            r_bcnt  <= w_bcnt_nxt;
`endif
            if (w_ld_acc) begin
                r_acc_max  <= w_m_max;
`ifdef MAX_ARGMAX_EN
                r_acc_idx  <= w_m_idx;
                r_acc_beat <= w_m_beat;
`endif
            end
            if (w_adv) begin
                r_ov <= w_bval && w_blast;
            end
            if (w_ld_out) begin
                r_omax  <= w_m_max;
`ifdef MAX_ARGMAX_EN
                r_oidx  <= w_m_idx;
                r_obeat <= w_m_beat;
`endif
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_ov;
    assign bus.out_max   = r_omax;
`ifdef MAX_ARGMAX_EN
    assign bus.out_idx   = r_oidx;
    assign bus.out_beat  = r_obeat;
`endif

endmodule

// File: doc/max_stream_reduce.md
# max_stream_reduce

Parametrised, pipelined N-channel maximum reducer. Each accepted beat carries N unsigned or signed WIDTH-bit operands. A registered comparator tree reduces them to one maximum, and an accumulator stage tracks the running maximum across a multi-beat frame delimited by `in_last`. One result is emitted per frame over a valid/ready handshake. It is the sequential, frame-aware successor to the combinational max partitions, and sits between the operand streamer and the result collector.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits (≥2).
- `N`, 4: channel count; power of two, ≥2. `L = log2(N)` tree stages, `IW = max(1, log2(N))`.
- `SIGNED`, 0: 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: beat accepted on an edge where `in_valid && in_ready`.
- `in_data` input N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_last` input 1: the beat is the final beat of its frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: result consumed on an edge where `out_valid && out_ready`.
- `out_max` output WIDTH: maximum over all operands of the frame.
- `out_idx` output IW: channel index of the winning operand. Present only with `MAX_ARGMAX_EN`.
- `out_beat` output 16: beat number within the frame (0-based) of the winning operand. Present only with `MAX_ARGMAX_EN`.

## Operation
- Global advance enable `adv = !out_valid || out_ready`. `in_ready = adv`, so `in_ready` depends combinationally on `out_ready`. When `adv` is 0, every pipeline register, the accumulator and the output register hold.
- Tree stage s (1..L) registers pairwise maxima of stage s-1 (stage 0 = `in_data`). Each stage carries a valid bit, `last`, and the winner's channel index.
  - Intra-beat tie: the lower channel index wins.
- Accumulator states:
  - IDLE (no partial frame).
  - ACC (partial frame held: `acc_max`, `acc_idx`, `acc_beat`, plus beat counter `bcnt`).
- Stage-L valid in IDLE: load the beat result as the accumulator, beat = 0, `bcnt = 1`.
- Stage-L valid in ACC: replace the accumulator only if the new value is strictly greater. An earlier beat wins ties. `bcnt` increments and saturates at 65535; `out_beat` saturates with it.
- If stage L's `last` = 1: load the final (merged) result into `out_max`/`out_idx`/`out_beat`, set `out_valid`, and return to IDLE in the same edge. A single-beat frame passes IDLE→IDLE.
- `out_valid` clears on the consuming handshake unless a new result loads on that same edge; in that case it stays 1 with the new data.
- Frames of unbounded length are supported; only `out_beat` saturates.
- `SIGNED` affects only compare, never data width.

## Timing
- Reset values: `out_valid` = 0, `out_max` = 0, `out_idx` = 0, `out_beat` = 0, all stage valids = 0, state IDLE, `bcnt` = 0. `in_ready` = 1 during and after reset.
- Reset mid-frame discards the partial frame and any in-flight beats. No output is produced for them.
- Latency: a last beat accepted on edge k makes `out_valid` = 1 after edge k+L, provided no stall occurs. The N=4 latency is 2 cycles.
- Throughput: one beat per cycle while `out_ready` = 1. Back-to-back single-beat frames yield one result per cycle.
- Stall: while `out_valid && !out_ready`, the output is stable and no beat is accepted. Data order is preserved.

## Configuration
- `MAX_ARGMAX_EN` defined:
  - `out_idx` and `out_beat` exist.
  - Index/beat tracking logic is compiled in with the tie rules above.
- Not defined:
  - Both ports and all index/beat registers are absent.
  - `out_max`, handshake and latency are identical.

## Test plan
- N=4, W=8, macro on: single-beat frame {3,9,9,1} (ch0..3), `in_last` = 1 accepted at edge k -> after edge k+2: `out_valid` = 1, `out_max` = 9, `out_idx` = 1, `out_beat` = 0.
- Three-beat frame with beat maxima 5, 12 (ch2), 12 (ch0) -> exactly one result: `out_max` = 12, `out_idx` = 2, `out_beat` = 1.
- {0x80,0xFF,0x05,0x7F} single beat:
  - SIGNED=0 -> `out_max` = 0xFF, `out_idx` = 1.
  - SIGNED=1 -> `out_max` = 0x7F, `out_idx` = 3.
- Back-to-back single-beat frames maxima 1,2,3,4 with `out_ready` = 0 for 5 cycles after first result -> `in_ready` = 0 while stalled, result held stable; results 1,2,3,4 emitted in order, none lost or duplicated.
- Two beats {50,..} without last, then `rst` pulse, then frame {1,2,3,4} last -> single result `out_max` = 4, `out_beat` = 0; no output from the aborted frame.
- Rebuild without `MAX_ARGMAX_EN`, rerun scenarios 1–4 -> identical `out_max`/`out_valid` cycle trace.
